// File: rtl/alu_control.sv
// RV32 ALU control: captures one instruction, decodes it, sequences DEC/EXE/WB/ERR.
// Define ALU_CTRL_ITYPE_EN to also decode OP-IMM (I-type) arithmetic instructions.
module alu_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  ALUop,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic        imm_sel,
    output logic        rd_we,
    output logic        illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b1101;

    typedef enum logic [2:0] {StIdle, StDec, StExe, StWb, StErr} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic        r_legal;
    logic [3:0]  r_aluop;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    logic        r_imm_sel;
    logic        r_rd_we;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_xfer;

    logic [3:0]  w_dec_op;
    logic        w_dec_legal;
    logic [4:0]  w_dec_rs2;
    logic [31:0] w_dec_imm;
    logic        w_dec_imm_sel;

    logic        w_ready_d;
    logic [3:0]  w_aluop_d;
    logic [4:0]  w_rs1_d;
    logic [4:0]  w_rs2_d;
    logic [4:0]  w_rd_d;
    logic [31:0] w_imm_d;
    logic        w_imm_sel_d;
    logic        w_rd_we_d;
    logic        w_illegal_d;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_funct7 = instr[31:25];
    assign w_xfer   = (r_state == StIdle) && instr_valid && r_ready;

    // Every legal encoding maps to a non-zero ALUop, so legality falls out of the op.
    always_comb begin
        w_dec_op      = ALU_NONE;
        w_dec_rs2     = w_rs2;
        w_dec_imm     = 32'd0;
        w_dec_imm_sel = 1'b0;
        if (w_opcode == OPC_R) begin
            case (w_funct3)
                3'b000: begin
                    if (w_funct7 == 7'b0000000) begin
                        w_dec_op = ALU_ADD;
                    end else if (w_funct7 == 7'b0100000) begin
                        w_dec_op = ALU_SUB;
                    end
                end
                3'b100:  w_dec_op = (w_funct7 == 7'd0) ? ALU_XOR : ALU_NONE;
                3'b110:  w_dec_op = (w_funct7 == 7'd0) ? ALU_OR  : ALU_NONE;
                3'b111:  w_dec_op = (w_funct7 == 7'd0) ? ALU_AND : ALU_NONE;
                3'b001:  w_dec_op = (w_funct7 == 7'd0) ? ALU_SLL : ALU_NONE;
                3'b101:  w_dec_op = (w_funct7 == 7'd0) ? ALU_SRL : ALU_NONE;
                default: w_dec_op = ALU_NONE;
            endcase
        end
`ifdef ALU_CTRL_ITYPE_EN
        else if (w_opcode == OPC_I) begin
            case (w_funct3)
                3'b000:  w_dec_op = ALU_ADD;
                3'b100:  w_dec_op = ALU_XOR;
                3'b110:  w_dec_op = ALU_OR;
                3'b111:  w_dec_op = ALU_AND;
                3'b001:  w_dec_op = (w_funct7 == 7'd0) ? ALU_SLL : ALU_NONE;
                3'b101:  w_dec_op = (w_funct7 == 7'd0) ? ALU_SRL : ALU_NONE;
                default: w_dec_op = ALU_NONE;
            endcase
            if (w_dec_op != ALU_NONE) begin
                w_dec_imm     = {{20{instr[31]}}, instr[31:20]};
                w_dec_imm_sel = 1'b1;
                w_dec_rs2     = 5'd0;
            end
        end
`endif
        w_dec_legal = (w_dec_op != ALU_NONE);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  w_state_next = w_xfer ? StDec : StIdle;
            StDec:   w_state_next = r_legal ? StExe : StErr;
            StExe:   w_state_next = StWb;
            StWb:    w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs are computed from the next state so that they are registered with it.
    always_comb begin
        w_ready_d   = (w_state_next == StIdle);
        w_aluop_d   = ALU_NONE;
        w_rs1_d     = 5'd0;
        w_rs2_d     = 5'd0;
        w_rd_d      = 5'd0;
        w_imm_d     = 32'd0;
        w_imm_sel_d = 1'b0;
        w_rd_we_d   = 1'b0;
        w_illegal_d = 1'b0;
        case (w_state_next)
            StDec: begin
                w_aluop_d   = w_dec_op;
                w_rs1_d     = w_rs1;
                w_rs2_d     = w_dec_rs2;
                w_rd_d      = w_rd;
                w_imm_d     = w_dec_imm;
                w_imm_sel_d = w_dec_imm_sel;
            end
            StExe, StWb: begin
                w_aluop_d   = r_aluop;
                w_rs1_d     = r_rs1;
                w_rs2_d     = r_rs2;
                w_rd_d      = r_rd;
                w_imm_d     = r_imm;
                w_imm_sel_d = r_imm_sel;
                w_rd_we_d   = (w_state_next == StWb) && (r_rd != 5'd0);
            end
            StErr:   w_illegal_d = 1'b1;
            default: w_illegal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ready   <= 1'b0;
            r_legal   <= 1'b0;
            r_aluop   <= ALU_NONE;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_imm     <= 32'd0;
            r_imm_sel <= 1'b0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= w_ready_d;
            r_aluop   <= w_aluop_d;
            r_rs1     <= w_rs1_d;
            r_rs2     <= w_rs2_d;
            r_rd      <= w_rd_d;
            r_imm     <= w_imm_d;
            r_imm_sel <= w_imm_sel_d;
            r_rd_we   <= w_rd_we_d;
            r_illegal <= w_illegal_d;
            if (w_xfer) begin
                r_legal <= w_dec_legal;
            end
        end
    end

    assign instr_ready = r_ready;
    assign ALUop       = r_aluop;
    assign rs1_addr    = r_rs1;
    assign rs2_addr    = r_rs2;
    assign rd_addr     = r_rd;
    assign imm         = r_imm;
    assign imm_sel     = r_imm_sel;
    assign rd_we       = r_rd_we;
    assign illegal     = r_illegal;

endmodule
